lcd_ctrl: RTL and testbench

//  Memory-mapped responder for the character-LCD output port driven by the core's store path.

---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lcd_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types and field positions for the HD44780-style character-LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_e;

  localparam int LCD_ON_BIT = 31;
  localparam int CTRL_BIT   = 30;
  localparam int RS_BIT     = 8;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  localparam int ST_BUSY_BIT = 0;
  localparam int ST_PEND_BIT = 1;
  localparam int ST_OVF_BIT  = 2;

  // CLEAR and HOME take far longer to execute inside the panel than any other command.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME);
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// Memory-mapped character-LCD responder: one pending slot, hardware-timed RS/EN/DATA
// sequencing and a polled status word.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PW    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_status,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data
);

  localparam int CW = $clog2(T_CLR + 1);
  typedef logic [CW-1:0] cnt_t;

  // Counters are loaded with length-1 so each state lasts exactly its parameter in cycles.
  localparam cnt_t C_SETUP = cnt_t'(T_SETUP - 1);
  localparam cnt_t C_PW    = cnt_t'(T_PW - 1);
  localparam cnt_t C_HOLD  = cnt_t'(T_HOLD - 1);
  localparam cnt_t C_EXEC  = cnt_t'(T_EXEC - 1);
  localparam cnt_t C_CLR   = cnt_t'(T_CLR - 1);

  lcd_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic       pend_vld_q, pend_vld_d;
  logic       pend_rs_q, pend_rs_d;
  logic [7:0] pend_byte_q, pend_byte_d;
  logic       ovf_q, ovf_d;
  logic       lcd_on_q, lcd_on_d;
  logic       en_q, en_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;

  logic pop, ctrl_wr, data_wr, cnt_done, busy;

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_rs_d   = pend_rs_q;
    pend_byte_d = pend_byte_q;
    ovf_d       = ovf_q;
    lcd_on_d    = lcd_on_q;
    en_d        = en_q;
    rs_d        = rs_q;
    data_d      = data_q;

    pop      = (state_q == ST_IDLE) && pend_vld_q;
    ctrl_wr  = i_wr_en && i_wr_data[CTRL_BIT];
    data_wr  = i_wr_en && !i_wr_data[CTRL_BIT];
    cnt_done = (cnt_q == '0);

    if (i_wr_en) lcd_on_d = i_wr_data[LCD_ON_BIT];
    if (ctrl_wr) ovf_d = 1'b0;
    if (pop)     pend_vld_d = 1'b0;

    // A write landing on the popping cycle reuses the slot being vacated.
    if (data_wr) begin
      if (!pend_vld_q || pop) begin
        pend_vld_d  = 1'b1;
        pend_rs_d   = i_wr_data[RS_BIT];
        pend_byte_d = i_wr_data[7:0];
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (!cnt_done) cnt_d = cnt_q - cnt_t'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          state_d = ST_SETUP;
          cnt_d   = C_SETUP;
          rs_d    = pend_rs_q;
          data_d  = pend_byte_q;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_d = ST_PULSE;
          cnt_d   = C_PW;
          en_d    = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_done) begin
          state_d = ST_HOLD;
          cnt_d   = C_HOLD;
          en_d    = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_d = ST_WAIT;
          cnt_d   = is_slow_cmd(rs_q, data_q) ? C_CLR : C_EXEC;
        end
      end
      ST_WAIT: begin
        if (cnt_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_byte_q <= '0;
      ovf_q       <= 1'b0;
      lcd_on_q    <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the same pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_rs_q   <= pend_rs_d;
      pend_byte_q <= pend_byte_d;
      ovf_q       <= ovf_d;
      lcd_on_q    <= lcd_on_d;
      en_q        <= en_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
    end
  end

  assign busy = (state_q != ST_IDLE) || pend_vld_q;

  always_comb begin
    o_status              = '0;
    o_status[ST_BUSY_BIT] = busy;
    o_status[ST_PEND_BIT] = pend_vld_q;
    o_status[ST_OVF_BIT]  = ovf_q;
  end

  assign o_lcd_on   = lcd_on_q;
  assign o_lcd_en   = en_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: directed timing checks plus a scoreboard of
// expected {RS,DATA} transfers compared on every EN rising edge.
module tb_lcd_ctrl;

  localparam int unsigned T_SETUP = 2;
  localparam int unsigned T_PW    = 4;
  localparam int unsigned T_HOLD  = 2;
  localparam int unsigned T_EXEC  = 10;
  localparam int unsigned T_CLR   = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [31:0] status;
  logic        lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0]  lcd_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int cur    = 0;
  int pulses = 0;
  int hi_len = 0;
  logic en_prev = 1'b0;
  logic [8:0] sb_q[$];

  lcd_ctrl #(
    .T_SETUP(T_SETUP), .T_PW(T_PW), .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_CLR(T_CLR)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .o_status   (status),
    .o_lcd_on   (lcd_on),
    .o_lcd_en   (lcd_en),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Transfer monitor: pop the scoreboard on each EN rise, check pulse width on each fall.
  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      pulses++;
      hi_len = 0;
      if (sb_q.size() == 0) check("sb_underflow", {23'b0, lcd_rs, lcd_data}, 32'hFFFF_FFFF);
      else check("sb_xfer", {23'b0, lcd_rs, lcd_data}, {23'b0, sb_q.pop_front()});
    end
    if (lcd_en) hi_len++;
    if (!lcd_en && en_prev && !rst) check("en_width", hi_len, T_PW);
    check("rw_tied", {31'b0, lcd_rw}, 32'h0);
    en_prev = lcd_en;
  end

  // One-cycle write; cur counts negedges after the accepting edge E0.
  task automatic write(input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0; wr_data = '0;
    cur = 0;
  endtask

  task automatic step_to(input int k);
    while (cur < k) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (status[0] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (status[0]) check("idle_timeout", 32'h1, 32'h0);
  endtask

  task automatic timed_xfer(input string tag, input logic [31:0] d, input int idle_edge);
    sb_q.push_back({d[8], d[7:0]});
    write(d);
    check({tag, "_st_e0"}, status, 32'h3);
    step_to(1);
    check({tag, "_rsdata_e1"}, {23'b0, lcd_rs, lcd_data}, {23'b0, d[8], d[7:0]});
    step_to(2);  check({tag, "_en_e2"}, {31'b0, lcd_en}, 32'h0);
    step_to(3);  check({tag, "_en_e3"}, {31'b0, lcd_en}, 32'h1);
    step_to(6);  check({tag, "_en_e6"}, {31'b0, lcd_en}, 32'h1);
    step_to(7);  check({tag, "_en_e7"}, {31'b0, lcd_en}, 32'h0);
    step_to(idle_edge - 1); check({tag, "_busy_pre"}, status, 32'h1);
    step_to(idle_edge);     check({tag, "_idle"}, status, 32'h0);
    check({tag, "_rsdata_hold"}, {23'b0, lcd_rs, lcd_data}, {23'b0, d[8], d[7:0]});
  endtask

  initial begin
    int p0;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0;

    // 1: reset and asynchronous re-assertion
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst_status", status, 32'h0);
    check("rst_outs", {22'b0, lcd_on, lcd_en, lcd_rs, lcd_data}, 32'h0);
    write(32'h8000_0000);
    check("ctrl_on", {31'b0, lcd_on}, 32'h1);
    #2 rst = 1'b1;
    #1 check("async_rst_on", {31'b0, lcd_on}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // 2: data write with LCD_ON
    timed_xfer("data", 32'h8000_0141, 19);
    check("data_on", {31'b0, lcd_on}, 32'h1);

    // 3: CLEAR and HOME use the long wait
    timed_xfer("clear", 32'h0000_0001, 39);
    timed_xfer("home", 32'h0000_0002, 39);

    // 4: three back-to-back writes, third dropped
    p0 = pulses;
    sb_q.push_back(9'h141);
    sb_q.push_back(9'h142);
    @(negedge clk); wr_en = 1'b1; wr_data = 32'h0000_0141;
    @(negedge clk); wr_data = 32'h0000_0142;
    @(negedge clk); wr_data = 32'h0000_0143;
    @(negedge clk); wr_en = 1'b0; wr_data = '0;
    check("ovf_status", status, 32'h7);

    // 5: control-only writes clear ovf and set LCD_ON without touching the queue
    write(32'hC000_0000);
    check("ctrl_ovf_clr", status, 32'h3);
    check("ctrl_on1", {31'b0, lcd_on}, 32'h1);
    write(32'h4000_0000);
    check("ctrl_on0", {31'b0, lcd_on}, 32'h0);
    check("ctrl_busy_kept", status, 32'h3);
    wait_idle(200);
    repeat (3) @(negedge clk);
    check("b2b_pulses", pulses - p0, 2);
    check("b2b_last", {23'b0, lcd_rs, lcd_data}, 32'h142);

    // 6: async reset in the middle of a pulse with an entry pending
    p0 = pulses;
    sb_q.push_back(9'h141);
    write(32'h0000_0141);
    write(32'h0000_0142);
    step_to(3);
    check("pre_rst_en", {31'b0, lcd_en}, 32'h1);
    check("pre_rst_st", status, 32'h3);
    #2 rst = 1'b1;
    #1 check("mid_rst_en", {31'b0, lcd_en}, 32'h0);
    check("mid_rst_st", status, 32'h0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_pulses", pulses - p0, 1);
    check("post_rst_st", status, 32'h0);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
